// File: rtl/dram_packer_pkg.sv
// ============================================================================
// Module      : dram_packer_pkg
// Description : Shared lane/PACK helpers and FIFO entry layout for the
//               DRAM stream packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dram_packer_pkg;

    localparam int c_defMemIfWidth = 128;
    localparam int c_defAdxWidth   = 27;

    // Number of samples that make up one memory word.
    function automatic int calcPack(input int memIfWidth, input int sampleWidth);
        return memIfWidth / sampleWidth;
    endfunction

    function automatic int laneIdxWidth(input int pack);
        return $clog2(pack);
    endfunction

    typedef struct packed {
        logic [c_defMemIfWidth-1:0] data;
        logic [c_defAdxWidth-1:0]   adx;
        logic                       partial;
    } fifoEntry_t;

endpackage

`default_nettype wire

// File: rtl/dram_stream_packer_if.sv
// ============================================================================
// Module      : dram_stream_packer_if
// Description : Sample-in / memory-word-out bus of the DRAM stream packer.
//               drop_count exists only with DRAM_STREAM_PACKER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dram_stream_packer_if #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int MEM_IF_WIDTH = 128,
    parameter int ADX_WIDTH    = 27
);
    logic                    we;
    logic [SAMPLE_WIDTH-1:0] write_data;
    logic                    flush;
    logic [MEM_IF_WIDTH-1:0] dram_data;
    logic [ADX_WIDTH-1:0]    dram_adx;
    logic                    dram_partial;
    logic                    write_req;
    logic                    write_allowed;
    logic                    overflow;
    logic                    wrapped;
    logic                    busy;
`ifdef DRAM_STREAM_PACKER_STATS_EN
    logic [15:0]             drop_count;
`endif

    modport slave (
        input  we, write_data, flush, write_allowed,
        output dram_data, dram_adx, dram_partial, write_req,
               overflow, wrapped, busy
`ifdef DRAM_STREAM_PACKER_STATS_EN
        , output drop_count
`endif
    );

    modport master (
        output we, write_data, flush, write_allowed,
        input  dram_data, dram_adx, dram_partial, write_req,
               overflow, wrapped, busy
`ifdef DRAM_STREAM_PACKER_STATS_EN
        , input drop_count
`endif
    );
endinterface

`default_nettype wire

// File: rtl/dram_word_fifo.sv
// ============================================================================
// Module      : dram_word_fifo
// Description : Two-entry word FIFO; a push into a full FIFO is accepted only
//               when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_word_fifo
    import dram_packer_pkg::*;
#(
    parameter type ENTRY_T = fifoEntry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  ENTRY_T pushData,
    output logic   full,
    output logic   empty,
    output ENTRY_T head
);
    ENTRY_T     r_mem [2];
    logic       r_wrPtr;
    logic       r_rdPtr;
    logic [1:0] r_count;
    logic       w_doPush;
    logic       w_doPop;

    assign full     = (r_count == 2'd2);
    assign empty    = (r_count == 2'd0);
    assign head     = r_mem[r_rdPtr];
    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_doPush) begin
                r_mem[r_wrPtr] <= pushData;
                r_wrPtr        <= ~r_wrPtr;
            end
            if (w_doPop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/dram_stream_packer.sv
// ============================================================================
// Module      : dram_stream_packer
// Description : Packs SAMPLE_WIDTH samples into MEM_IF_WIDTH memory words with
//               sequential addresses. Optional drop counter: define
//               DRAM_STREAM_PACKER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dram_stream_packer
    import dram_packer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 32,
    parameter int MEM_IF_WIDTH = 128,
    parameter int ADX_WIDTH    = 27,
    parameter int ADX_STEP     = 8,
    parameter int ADX_LIMIT    = 2**27
) (
    input  logic                clk,
    input  logic                reset,
    dram_stream_packer_if.slave bus
);
    localparam int c_pack  = calcPack(MEM_IF_WIDTH, SAMPLE_WIDTH);
    localparam int c_laneW = laneIdxWidth(c_pack);
    localparam logic [c_laneW-1:0] c_laneLast = c_laneW'(c_pack - 1);
    localparam logic [ADX_WIDTH:0] c_adxStep  = (ADX_WIDTH+1)'(ADX_STEP);
    localparam logic [ADX_WIDTH:0] c_adxLimit = (ADX_WIDTH+1)'(ADX_LIMIT);

    typedef struct packed {
        logic [MEM_IF_WIDTH-1:0] data;
        logic [ADX_WIDTH-1:0]    adx;
        logic                    partial;
    } entry_t;

    logic [c_laneW-1:0]      r_lane;
    logic [MEM_IF_WIDTH-1:0] r_assembly;
    logic [ADX_WIDTH-1:0]    r_adx;
    logic                    r_overflow;
    logic                    r_wrapped;

    logic [MEM_IF_WIDTH-1:0] w_merged;
    logic [ADX_WIDTH:0]      w_adxNext;
    logic                    w_pushFull;
    logic                    w_pushPartial;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_full;
    logic                    w_empty;
    entry_t                  w_pushEntry;
    entry_t                  w_head;

    // Unwritten lanes stay zero because the assembly register clears on each push.
    always_comb begin
        w_merged = r_assembly;
        w_merged[r_lane*SAMPLE_WIDTH +: SAMPLE_WIDTH] = bus.write_data;
    end

    assign w_pushFull    = bus.we && (r_lane == c_laneLast);
    assign w_pushPartial = bus.flush && !w_pushFull && (bus.we || (r_lane != '0));
    assign w_push        = w_pushFull || w_pushPartial;
    assign w_pop         = !w_empty && bus.write_allowed;
    assign w_accept      = w_push && (!w_full || w_pop);
    assign w_drop        = w_push && w_full && !w_pop;
    assign w_adxNext     = {1'b0, r_adx} + c_adxStep;

    assign w_pushEntry.data    = bus.we ? w_merged : r_assembly;
    assign w_pushEntry.adx     = r_adx;
    assign w_pushEntry.partial = w_pushPartial;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane     <= '0;
            r_assembly <= '0;
        end else if (w_push) begin
            r_lane     <= '0;
            r_assembly <= '0;
        end else if (bus.we) begin
            r_lane     <= r_lane + c_laneW'(1);
            r_assembly <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adx      <= '0;
            r_overflow <= 1'b0;
            r_wrapped  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_adxNext >= c_adxLimit) begin
                    r_adx     <= '0;
                    r_wrapped <= 1'b1;
                end else begin
                    r_adx <= w_adxNext[ADX_WIDTH-1:0];
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    dram_word_fifo #(
        .ENTRY_T (entry_t)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .pop      (w_pop),
        .pushData (w_pushEntry),
        .full     (w_full),
        .empty    (w_empty),
        .head     (w_head)
    );

    // Head is masked while empty so stale storage never reaches the bus.
    assign bus.write_req    = !w_empty;
    assign bus.dram_data    = w_empty ? '0 : w_head.data;
    assign bus.dram_adx     = w_empty ? '0 : w_head.adx;
    assign bus.dram_partial = !w_empty && w_head.partial;
    assign bus.overflow     = r_overflow;
    assign bus.wrapped      = r_wrapped;
    assign bus.busy         = (r_lane != '0) || !w_empty;

`ifdef DRAM_STREAM_PACKER_STATS_EN
    logic [15:0] r_dropCount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dropCount <= '0;
        end else if (w_drop && (r_dropCount != 16'hFFFF)) begin
            r_dropCount <= r_dropCount + 16'd1;
        end
    end

    assign bus.drop_count = r_dropCount;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dram_stream_packer.sv
// ============================================================================
// Module      : tb_dram_stream_packer
// Description : Directed bench for dram_stream_packer (default instance plus
//               an ADX_LIMIT=32 instance for address wrap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dram_stream_packer;

    logic clk;
    logic reset;
    int   nChecks;
    int   nFails;

    dram_stream_packer_if #(.SAMPLE_WIDTH(32), .MEM_IF_WIDTH(128), .ADX_WIDTH(27)) ifD ();
    dram_stream_packer_if #(.SAMPLE_WIDTH(32), .MEM_IF_WIDTH(128), .ADX_WIDTH(27)) ifW ();

    dram_stream_packer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifD)
    );

    dram_stream_packer #(.ADX_LIMIT(32)) dutWrap (
        .clk   (clk),
        .reset (reset),
        .bus   (ifW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkEq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIn(input logic w, input logic [31:0] d, input logic f);
        ifD.we = w; ifD.write_data = d; ifD.flush = f;
        ifW.we = w; ifW.write_data = d; ifW.flush = f;
    endtask

    task automatic setWa(input logic v);
        ifD.write_allowed = v;
        ifW.write_allowed = v;
    endtask

    task automatic sample(input logic [31:0] d, input logic f);
        setIn(1'b1, d, f);
        tick();
        setIn(1'b0, 32'h0, 1'b0);
    endtask

    task automatic doReset();
        setIn(1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [26:0] expAdx [5];

    initial begin
        nChecks = 0;
        nFails  = 0;
        reset   = 1'b0;
        setWa(1'b0);
        setIn(1'b0, 32'h0, 1'b0);
        expAdx = '{27'd0, 27'd8, 27'd16, 27'd24, 27'd0};

        // Reset state
        doReset();
        checkEq("rst_write_req", ifD.write_req, 1'b0);
        checkEq("rst_busy", ifD.busy, 1'b0);
        checkEq("rst_data", ifD.dram_data, '0);
        checkEq("rst_adx", ifD.dram_adx, '0);
        checkEq("rst_flags", {ifD.overflow, ifD.wrapped, ifD.dram_partial}, 3'b000);

        // Basic pack
        setWa(1'b1);
        for (int i = 1; i <= 4; i++) sample(32'(i), 1'b0);
        checkEq("basic_req", ifD.write_req, 1'b1);
        checkEq("basic_data", ifD.dram_data, 128'h00000004_00000003_00000002_00000001);
        checkEq("basic_adx", ifD.dram_adx, 27'd0);
        checkEq("basic_partial", ifD.dram_partial, 1'b0);
        tick();
        checkEq("basic_popped", {ifD.write_req, ifD.busy}, 2'b00);

        // Empty flush, then partial flush
        doReset();
        setWa(1'b0);
        setIn(1'b0, 32'h0, 1'b1);
        tick();
        setIn(1'b0, 32'h0, 1'b0);
        checkEq("flush_empty", {ifD.write_req, ifD.busy}, 2'b00);
        sample(32'hA, 1'b0);
        sample(32'hB, 1'b0);
        setIn(1'b0, 32'h0, 1'b1);
        tick();
        setIn(1'b0, 32'h0, 1'b0);
        checkEq("partial_data", ifD.dram_data, 128'h0000000B_0000000A);
        checkEq("partial_flag", ifD.dram_partial, 1'b1);
        checkEq("partial_adx", ifD.dram_adx, 27'd0);
        tick();
        checkEq("partial_stable", {ifD.write_req, ifD.dram_partial}, 2'b11);
        setWa(1'b1);
        tick();
        setWa(1'b0);
        for (int i = 5; i <= 8; i++) sample(32'(i), 1'b0);
        checkEq("next_adx", ifD.dram_adx, 27'd8);
        checkEq("next_data", ifD.dram_data, 128'h00000008_00000007_00000006_00000005);
        checkEq("next_partial", ifD.dram_partial, 1'b0);

        // Backpressure: third word dropped
        doReset();
        setWa(1'b0);
        for (int i = 0; i < 12; i++) sample(32'h11 + 32'(i), 1'b0);
        checkEq("bp_overflow", ifD.overflow, 1'b1);
        checkEq("bp_head_adx", ifD.dram_adx, 27'd0);
        checkEq("bp_head_data", ifD.dram_data, 128'h00000014_00000013_00000012_00000011);
`ifdef DRAM_STREAM_PACKER_STATS_EN
        checkEq("bp_drop_count", ifD.drop_count, 16'd1);
`endif
        setWa(1'b1);
        tick();
        checkEq("bp_second_adx", ifD.dram_adx, 27'd8);
        checkEq("bp_second_data", ifD.dram_data, 128'h00000018_00000017_00000016_00000015);
        tick();
        checkEq("bp_drained", {ifD.write_req, ifD.busy, ifD.overflow}, 3'b001);

        // Push and pop on a full FIFO in the same cycle
        doReset();
        setWa(1'b0);
        for (int i = 0; i < 11; i++) sample(32'h21 + 32'(i), 1'b0);
        setWa(1'b1);
        sample(32'h2C, 1'b0);
        checkEq("pp_no_overflow", ifD.overflow, 1'b0);
        checkEq("pp_head_adx", ifD.dram_adx, 27'd8);
        tick();
        checkEq("pp_third_adx", ifD.dram_adx, 27'd16);
        checkEq("pp_third_data", ifD.dram_data, 128'h0000002C_0000002B_0000002A_00000029);

        // Address wrap on the ADX_LIMIT=32 instance
        doReset();
        setWa(1'b1);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) sample(32'(k*4 + j), 1'b0);
            checkEq($sformatf("wrap_adx%0d", k), ifW.dram_adx, expAdx[k]);
            if (k == 2) checkEq("wrap_not_yet", ifW.wrapped, 1'b0);
        end
        checkEq("wrap_flag", ifW.wrapped, 1'b1);
        checkEq("wrap_main_clear", ifD.wrapped, 1'b0);

        // Reset during a pending handshake with 2 lanes filled
        doReset();
        setWa(1'b0);
        for (int i = 0; i < 6; i++) sample(32'h40 + 32'(i), 1'b0);
        checkEq("rmh_pending", ifD.write_req, 1'b1);
        reset = 1'b1;
        setWa(1'b1);
        setIn(1'b1, 32'h99, 1'b1);
        tick();
        reset = 1'b0;
        setIn(1'b0, 32'h0, 1'b0);
        checkEq("rmh_cleared", {ifD.write_req, ifD.busy}, 2'b00);
        setWa(1'b0);
        for (int i = 0; i < 4; i++) sample(32'h50 + 32'(i), 1'b0);
        checkEq("rmh_adx", ifD.dram_adx, 27'd0);
        checkEq("rmh_data", ifD.dram_data, 128'h00000053_00000052_00000051_00000050);

        // we and flush together on the last lane
        doReset();
        setWa(1'b0);
        for (int i = 0; i < 3; i++) sample(32'h60 + 32'(i), 1'b0);
        sample(32'h63, 1'b1);
        checkEq("wf_partial", {ifD.write_req, ifD.dram_partial}, 2'b10);
        checkEq("wf_data", ifD.dram_data, 128'h00000063_00000062_00000061_00000060);
        setWa(1'b1);
        tick();
        checkEq("wf_single", {ifD.write_req, ifD.busy}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

`default_nettype wire
